// File: rtl/nr_capture.sv
// Button conditioning and three-nibble result capture for the pseudorandom digit generator.
// Optional macro NR_CAPTURE_BCD_EN folds nibbles above 9 into 0..5 so cur/prev stay BCD.
module nr_capture #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start_btn,
   input  logic        stop_btn,
   input  logic [3:0]  data_in,
   output logic        start_pulse,
   output logic        stop_pulse,
   output logic [11:0] prev,
   output logic [11:0] cur,
   output logic [1:0]  digit_cnt,
   output logic        busy,
   output logic        done
);

   typedef enum logic [1:0] {
      WAIT_START = 2'd0,
      WAIT_STOP  = 2'd1,
      COMMIT     = 2'd2
   } state_t;

   localparam logic [7:0] DB_LIMIT = 8'(DEBOUNCE_CYCLES);

   logic [1:0] btn_raw;
   logic [1:0] edge_raw;

   assign btn_raw = {stop_btn, start_btn};

   // Bit 0 conditions the start button, bit 1 the stop button.
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_btn
         logic       sync1_reg;
         logic       sync2_reg;
         logic       deb_reg;
         logic       deb_d_reg;
         logic       edge_reg;
         logic [7:0] cnt_reg;

         always_ff @(posedge clk) begin
            if (rst) begin
               sync1_reg <= 1'b0;
               sync2_reg <= 1'b0;
               deb_reg   <= 1'b0;
               deb_d_reg <= 1'b0;
               edge_reg  <= 1'b0;
               cnt_reg   <= 8'd0;
            end else begin
               sync1_reg <= btn_raw[gi];
               sync2_reg <= sync1_reg;
               deb_d_reg <= deb_reg;
               edge_reg  <= deb_reg & ~deb_d_reg;
               if (sync2_reg == deb_reg) begin
                  cnt_reg <= 8'd0;
               end else if (cnt_reg == DB_LIMIT) begin
                  deb_reg <= ~deb_reg;
                  cnt_reg <= 8'd0;
               end else begin
                  cnt_reg <= cnt_reg + 8'd1;
               end
            end
         end

         assign edge_raw[gi] = edge_reg;
      end
   endgenerate

   state_t      state_reg, state_next;
   logic [11:0] cur_reg, cur_next;
   logic [11:0] prev_reg, prev_next;
   logic [1:0]  digit_cnt_reg, digit_cnt_next;
   logic [3:0]  nib;

`ifdef NR_CAPTURE_BCD_EN
   assign nib = (data_in > 4'd9) ? (data_in - 4'd10) : data_in;
`else
   assign nib = data_in;
`endif

   // Edges outside the matching state are dropped so the generator's toggle tracks the FSM.
   assign start_pulse = edge_raw[0] && (state_reg == WAIT_START);
   assign stop_pulse  = edge_raw[1] && (state_reg == WAIT_STOP);

   always_comb begin
      state_next     = state_reg;
      cur_next       = cur_reg;
      prev_next      = prev_reg;
      digit_cnt_next = digit_cnt_reg;
      case (state_reg)
         WAIT_START: begin
            if (start_pulse) begin
               state_next = WAIT_STOP;
               if (digit_cnt_reg == 2'd0) begin
                  cur_next = 12'h000;
               end
            end
         end
         WAIT_STOP: begin
            if (stop_pulse) begin
               case (digit_cnt_reg)
                  2'd0:    cur_next[11:8] = nib;
                  2'd1:    cur_next[7:4]  = nib;
                  default: cur_next[3:0]  = nib;
               endcase
               if (digit_cnt_reg == 2'd2) begin
                  state_next = COMMIT;
               end else begin
                  digit_cnt_next = digit_cnt_reg + 2'd1;
                  state_next     = WAIT_START;
               end
            end
         end
         COMMIT: begin
            prev_next      = cur_reg;
            digit_cnt_next = 2'd0;
            state_next     = WAIT_START;
         end
         default: begin
            state_next = WAIT_START;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= WAIT_START;
         cur_reg       <= 12'h000;
         prev_reg      <= 12'h000;
         digit_cnt_reg <= 2'd0;
      end else begin
         state_reg     <= state_next;
         cur_reg       <= cur_next;
         prev_reg      <= prev_next;
         digit_cnt_reg <= digit_cnt_next;
      end
   end

   assign prev      = prev_reg;
   assign cur       = cur_reg;
   assign digit_cnt = digit_cnt_reg;
   assign done      = (state_reg == COMMIT);
   assign busy      = (state_reg != WAIT_START) || (digit_cnt_reg != 2'd0);

endmodule

// File: doc/nr_capture.md
Name: nr_capture

Overview:
- Front-end and result stage around the pseudorandom digit generator.
- Debounces the raw start/stop buttons and emits single-cycle start/stop pulses that drive the generator's toggle.
- Samples the generator's 4-bit output on each accepted stop and assembles three nibbles into a 12-bit number.
- Holds the last completed number as `prev`, which feeds back into the generator's `prev` input.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive clocks a synchronized button level must differ from the debounced level before the debounced level flips (range 1..255).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start_btn  input  1  raw asynchronous start button level.
- stop_btn  input  1  raw asynchronous stop button level.
- data_in  input  4  generator digit output, sampled on accepted stop.
- start_pulse  output  1  one-cycle accepted start; drives the generator start.
- stop_pulse  output  1  one-cycle accepted stop; drives the generator stop.
- prev  output  12  last completed number, MS nibble first.
- cur  output  12  number under construction.
- digit_cnt  output  2  nibbles captured in the current draw, 0..2.
- busy  output  1  a draw is in progress.
- done  output  1  one-cycle pulse when `prev` updates.

Behaviour:
- Reset (sync, `rst`=1 at a clock edge):
  - Cleared to 0: sync flops, debounced levels, debounce counters, state=WAIT_START, prev, cur, digit_cnt, start_pulse, stop_pulse, busy, done.
  - Reset has priority over every other event.
  - A button held high across reset release produces a pulse after the normal debounce latency.
- Input conditioning, per button, identical paths:
  - 2-flop synchronizer.
  - Counter increments while the synchronized level differs from the debounced level, and clears when they are equal.
  - When the counter reaches DEBOUNCE_CYCLES, the debounced level flips and the counter clears.
  - Raw edge = debounced level 0→1, registered.
  - Latency: a clean press held stable yields the raw edge DEBOUNCE_CYCLES+3 clock edges after the first edge that samples the button high.
  - Releases produce no pulse.
- Gating: the raw start edge is emitted as `start_pulse` only when state=WAIT_START; the raw stop edge is emitted as `stop_pulse` only when state=WAIT_STOP. Edges arriving in any other state are dropped, never queued. This keeps the generator's toggle flop in step with the FSM.
- FSM, state WAIT_START:
  - On `start_pulse`: go to WAIT_STOP.
  - If digit_cnt=0, also clear `cur` to 0 on that edge.
- FSM, state WAIT_STOP:
  - On `stop_pulse`: write `data_in` (as sampled in the same cycle) to `cur[11-4*digit_cnt -: 4]`.
  - If digit_cnt=2: go to COMMIT. Otherwise: digit_cnt+1, go to WAIT_START.
- FSM, state COMMIT (exactly 1 cycle):
  - `prev` <= `cur`, `done`=1, digit_cnt <= 0, go to WAIT_START.
  - `cur` keeps its value until the next draw's first start.
- busy = (state≠WAIT_START) or (digit_cnt≠0).
- done is high only during the COMMIT cycle. prev changes on the edge that ends COMMIT.
- Simultaneous raw start and stop edges: at most one is accepted, decided by state.
- Mid-draw reset: the partial `cur` is discarded (cleared). The generator sees no further pulses.

Optional Feature:
- Macro NR_CAPTURE_BCD_EN.
- Defined: the captured nibble is stored as data_in-10 when data_in>9, else data_in, so `cur`/`prev` are always 3-digit BCD.
- Undefined: data_in is stored unmodified (0..F).

Test Plan:
1. Assert rst 2 cycles with both buttons low → prev=12'h000, cur=12'h000, digit_cnt=0, busy=0, done=0, no pulses for 20 cycles.
2. start_btn high for 3 cycles then low (DEBOUNCE_CYCLES=4) → no start_pulse. Held high continuously → exactly one start_pulse, 7 edges after first high sample.
3. Three start/stop pairs with data_in=4'hA, 4'h3, 4'h7 at the respective stop_pulses → prev=12'hA37, done high one cycle, the cycle after the third stop_pulse. With NR_CAPTURE_BCD_EN: prev=12'h037.
4. In WAIT_START press stop_btn; in WAIT_STOP press start_btn → neither pulse emitted, cur/digit_cnt unchanged.
5. After two captured nibbles (digit_cnt=2) assert rst → cur=0, prev=0, digit_cnt=0, state WAIT_START. A following full draw 1,2,3 gives prev=12'h123.
6. Back-to-back draws 5,5,5 then 1,0,F → prev 12'h555 then 12'h10F. cur is cleared at the second draw's first start_pulse.
